// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM encoding, port ids and default depth for the memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_RESP = 2'd2,
        S_ERR  = 2'd3
    } state_t;
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_HOST = 1'b1;
    localparam int unsigned DEPTH_DEF = 256;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way picker, fixed priority to port 0 or round-robin on ties
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    input  logic       fixed_pri,
    output logic       winner,
    output logic       any
);
    assign any = |req;
    assign winner = (&req && (fixed_pri || last_owner == PORT_HOST)) ? PORT_CPU :
                    (req[1] ? PORT_HOST : PORT_CPU);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises two requesters onto a single-port byte memory;
// every output is registered, so pins trail the FSM state by one edge.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout,
    output logic        busy
);
    state_t state, state_nx;
    logic last_owner, owner, lat_we, pend_rd, pend_err, win, any, pend;
    logic [15:0] lat_addr, lat_wdata, w_addr;

    rr_pick2 u_pick (
        .req       ({req1, req0}),
        .last_owner(last_owner),
        .fixed_pri (FIXED_PRI),
        .winner    (win),
        .any       (any)
    );

    assign w_addr = win ? addr1 : addr0;
    assign pend = pend_rd || pend_err;

    always_comb begin
        state_nx = S_IDLE;
        if (state == S_IDLE && any)
            state_nx = ({16'd0, w_addr} < DEPTH) ? S_CMD : S_ERR;
        else if (state == S_CMD && !lat_we)
            state_nx = S_RESP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Responses lag the state by one more edge so the registered memory read is captured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= PORT_HOST;
            owner <= PORT_CPU;
            lat_we <= 1'b0;
            lat_addr <= '0;
            lat_wdata <= '0;
            pend_rd <= 1'b0;
            pend_err <= 1'b0;
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
            mem_read <= 1'b0;
            mem_write <= 1'b0;
            mem_addr <= '0;
            mem_din <= '0;
            busy <= 1'b0;
        end else begin
            if (state == S_IDLE && any) begin
                owner <= win;
                last_owner <= win;
                lat_we <= win ? we1 : we0;
                lat_addr <= w_addr;
                lat_wdata <= win ? wdata1 : wdata0;
            end
            gnt0 <= (state == S_CMD || state == S_ERR) && owner == PORT_CPU;
            gnt1 <= (state == S_CMD || state == S_ERR) && owner == PORT_HOST;
            mem_read <= state == S_CMD && !lat_we;
            mem_write <= state == S_CMD && lat_we;
            mem_addr <= state == S_CMD ? lat_addr : '0;
            mem_din <= state == S_CMD ? lat_wdata : '0;
            pend_rd <= state == S_RESP;
            pend_err <= state == S_ERR;
            rvalid0 <= pend && owner == PORT_CPU;
            rvalid1 <= pend && owner == PORT_HOST;
            err0 <= pend_err && owner == PORT_CPU;
            err1 <= pend_err && owner == PORT_HOST;
            if (pend && owner == PORT_CPU)
                rdata0 <= pend_err ? '0 : mem_dout;
            if (pend && owner == PORT_HOST)
                rdata1 <= pend_err ? '0 : mem_dout;
            busy <= state_nx != S_IDLE;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random accesses against a transaction-level memory model,
// plus a fixed-priority instance and a mid-access reset.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic        req [2];
    logic        we [2];
    logic [15:0] addr [2];
    logic [15:0] wdata [2];
    logic        gnt [2];
    logic        rvalid [2];
    logic        err [2];
    logic [15:0] rdata [2];
    logic        mem_read, mem_write, busy;
    logic [15:0] mem_addr, mem_din;
    logic [15:0] mem_dout = 16'h0;
    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];

    logic        f_req [2];
    logic        f_gnt [2];
    logic        f_rvalid [2];
    logic        f_err [2];
    logic [15:0] f_rdata [2];
    logic        f_mr, f_mw, f_busy;
    logic [15:0] f_ma, f_md;

    int compared = 0;
    int mismatched = 0;
    int both_strobe = 0;
    int rv_overlap = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
        .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
        .gnt0(gnt[0]), .gnt1(gnt[1]), .rvalid0(rvalid[0]), .rvalid1(rvalid[1]),
        .rdata0(rdata[0]), .rdata1(rdata[1]), .err0(err[0]), .err1(err[1]),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
    );

    mem_arbiter #(.FIXED_PRI(1'b1)) u_fix (
        .clk(clk), .rst_n(rst_n),
        .req0(f_req[0]), .req1(f_req[1]), .we0(1'b0), .we1(1'b0),
        .addr0(16'h0003), .addr1(16'h0004), .wdata0(16'h0), .wdata1(16'h0),
        .gnt0(f_gnt[0]), .gnt1(f_gnt[1]), .rvalid0(f_rvalid[0]), .rvalid1(f_rvalid[1]),
        .rdata0(f_rdata[0]), .rdata1(f_rdata[1]), .err0(f_err[0]), .err1(f_err[1]),
        .mem_read(f_mr), .mem_write(f_mw), .mem_addr(f_ma),
        .mem_din(f_md), .mem_dout(16'h0), .busy(f_busy)
    );

    // External 256x8 memory with registered read
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:0]] <= mem_din[7:0];
        if (mem_read) mem_dout <= {8'h00, mem[mem_addr[7:0]]};
    end

    always @(negedge clk) begin
        if (mem_read && mem_write) both_strobe++;
        if (rvalid[0] && rvalid[1]) rv_overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        compared++;
        assert (obs === want) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic access(input int p, input logic w, input logic [15:0] a, input logic [15:0] d);
        int c;
        logic inr;
        logic [15:0] want;
        inr = a < 16'd256;
        want = inr ? {8'h00, ref_mem[a[7:0]]} : 16'h0000;
        we[p] = w; addr[p] = a; wdata[p] = d; req[p] = 1'b1;
        c = 0;
        while (c < 20 && gnt[p] !== 1'b1) begin @(posedge clk); #1; c++; end
        chk("gnt_latency", c, 2);
        req[p] = 1'b0;
        chk("gnt_other", gnt[1-p], 0);
        chk("mem_read", mem_read, inr && !w);
        chk("mem_write", mem_write, inr && w);
        chk("busy", busy, inr && !w);
        if (inr) begin
            chk("mem_addr", mem_addr, a);
            chk("mem_din", mem_din, d);
        end
        if (inr && w) ref_mem[a[7:0]] = d[7:0];
        c = 0;
        while (c < 6 && rvalid[p] !== 1'b1) begin @(posedge clk); #1; c++; end
        if (inr && w)
            chk("write_no_rvalid", c, 6);
        else begin
            chk("rvalid_latency", c, inr ? 2 : 1);
            chk("rdata", rdata[p], want);
            chk("err", err[p], !inr);
            chk("rvalid_other", rvalid[1-p], 0);
        end
    endtask

    task automatic tie(input logic [15:0] a0, input logic [15:0] a1, input int f);
        int o, g2, r1, r2;
        logic [15:0] wf, wo;
        o = 1 - f;
        addr[0] = a0; addr[1] = a1; we[0] = 1'b0; we[1] = 1'b0;
        wf = {8'h00, ref_mem[addr[f][7:0]]};
        wo = {8'h00, ref_mem[addr[o][7:0]]};
        req[0] = 1'b1; req[1] = 1'b1;
        g2 = 0; r1 = 0; r2 = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 2) begin
                chk("tie_winner", {gnt[1], gnt[0]}, (f == 1) ? 2'b10 : 2'b01);
                req[f] = 1'b0;
            end
            if (gnt[o] === 1'b1) begin g2 = c; req[o] = 1'b0; end
            if (rvalid[f] === 1'b1) begin r1 = c; chk("tie_rdata_first", rdata[f], wf); end
            if (rvalid[o] === 1'b1) begin r2 = c; chk("tie_rdata_second", rdata[o], wo); end
        end
        req[0] = 1'b0; req[1] = 1'b0;
        chk("tie_second_gnt_cycle", g2, 5);
        chk("tie_first_rvalid_cycle", r1, 4);
        chk("tie_second_rvalid_cycle", r2, 7);
    endtask

    initial begin
        int c, n0, n1, g;
        logic w;
        logic [15:0] a;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0; f_req[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", |{gnt[0], gnt[1], rvalid[0], rvalid[1], err[0], err[1], rdata[0], rdata[1],
                              mem_read, mem_write, mem_addr, mem_din, busy}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 256; i++) access(i % 2, 1'b1, 16'(i), 16'($urandom));

        access(0, 1'b1, 16'h0010, 16'h00AB);
        access(0, 1'b0, 16'h0010, 16'h0000);
        chk("plan_rdata0", rdata[0], 16'h00AB);

        access(1, 1'b1, 16'h0005, 16'h0002);
        access(1, 1'b1, 16'h0006, 16'h00B6);
        tie(16'h0005, 16'h0006, 0);
        chk("tie_rdata0", rdata[0], 16'h0002);
        chk("tie_rdata1", rdata[1], 16'h00B6);
        tie(16'h0005, 16'h0006, 0);

        access(0, 1'b0, 16'h0100, 16'h0000);
        access(1, 1'b1, 16'hFFFF, 16'h1234);
        access(1, 1'b1, 16'h00FF, 16'h12FF);
        access(1, 1'b0, 16'h00FF, 16'h0000);
        chk("boundary_rdata1", rdata[1], 16'h00FF);

        for (int i = 0; i < 60; i++) begin
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            access(int'($urandom_range(0, 1)), w, a, 16'($urandom));
        end

        // Abort a port-0 read during its response phase
        addr[0] = 16'h0020; we[0] = 1'b0; req[0] = 1'b1;
        c = 0;
        while (c < 20 && gnt[0] !== 1'b1) begin @(posedge clk); #1; c++; end
        chk("abort_gnt", c, 2);
        req[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs_zero", |{gnt[0], gnt[1], rvalid[0], rvalid[1], err[0], err[1], rdata[0], rdata[1],
                                   mem_read, mem_write, mem_addr, mem_din, busy}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rvalid[0] || rvalid[1] || gnt[0] || gnt[1] || mem_read || mem_write) n0++;
            if (busy) n1++;
        end
        chk("abort_no_activity", n0, 0);
        chk("abort_not_busy", n1, 0);
        tie(16'h0006, 16'h0005, 0);

        // Fixed priority: port 0 monopolises while it keeps requesting
        f_req[0] = 1'b1; f_req[1] = 1'b1;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (f_gnt[0]) n0++;
            if (f_gnt[1]) n1++;
        end
        chk("fixed_gnt0_count", n0, 10);
        chk("fixed_gnt1_count", n1, 0);
        f_req[0] = 1'b0;
        g = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (f_gnt[1] === 1'b1 && g == 0) begin g = i; f_req[1] = 1'b0; end
        end
        f_req[1] = 1'b0;
        chk("fixed_gnt1_after_drop", g, 2);

        chk("strobes_exclusive", both_strobe, 0);
        chk("rvalid_no_overlap", rv_overlap, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
